// File: rtl/cpu_branch_predictor.sv
// rtl/cpu_branch_predictor.sv - direct-mapped 2-bit-counter branch predictor with target buffer
module cpu_branch_predictor #(
  parameter int ENTRY_COUNT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        query_valid,
  input  logic [31:0] query_pc,
  output logic        predict_valid,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        flush
);

  localparam int INDEX_BITS = $clog2(ENTRY_COUNT);
  localparam int TAG_BITS   = 30 - INDEX_BITS;

  logic [ENTRY_COUNT-1:0] r_valid;
  logic [TAG_BITS-1:0]    r_tag     [ENTRY_COUNT];
  logic [31:0]            r_target  [ENTRY_COUNT];
  logic [1:0]             r_counter [ENTRY_COUNT];

  logic                   r_predict_valid;
  logic                   r_predict_taken;
  logic [31:0]            r_predict_target;

  logic [INDEX_BITS-1:0]  w_q_index;
  logic [TAG_BITS-1:0]    w_q_tag;
  logic                   w_q_hit;
  logic                   w_q_taken;
  logic [31:0]            w_q_target;

  logic [INDEX_BITS-1:0]  w_u_index;
  logic [TAG_BITS-1:0]    w_u_tag;
  logic                   w_u_hit;
  logic                   w_u_write;
  logic [1:0]             w_u_counter_next;
  logic                   w_unused;

  assign w_unused = ^{query_pc[1:0], update_pc[1:0]};

  // Lookup reads the table as it stands before this edge's update, giving read-before-write.
  assign w_q_index  = query_pc[INDEX_BITS+1:2];
  assign w_q_tag    = query_pc[31:INDEX_BITS+2];
  assign w_q_hit    = r_valid[w_q_index] && (r_tag[w_q_index] == w_q_tag);
  assign w_q_taken  = w_q_hit && r_counter[w_q_index][1];
  assign w_q_target = w_q_taken ? r_target[w_q_index] : (query_pc + 32'd4);

  assign w_u_index  = update_pc[INDEX_BITS+1:2];
  assign w_u_tag    = update_pc[31:INDEX_BITS+2];
  assign w_u_hit    = r_valid[w_u_index] && (r_tag[w_u_index] == w_u_tag);
  assign w_u_write  = update_valid && !flush && (w_u_hit || update_taken);

  always_comb begin
    w_u_counter_next = r_counter[w_u_index];
    if (update_taken && (r_counter[w_u_index] != 2'b11)) begin
      w_u_counter_next = r_counter[w_u_index] + 2'd1;
    end else if (!update_taken && (r_counter[w_u_index] != 2'b00)) begin
      w_u_counter_next = r_counter[w_u_index] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_predict_valid  <= 1'b0;
      r_predict_taken  <= 1'b0;
      r_predict_target <= 32'd0;
    end else begin
      r_predict_valid  <= query_valid;
      r_predict_taken  <= query_valid && w_q_taken;
      r_predict_target <= query_valid ? w_q_target : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (update_valid && update_taken && !w_u_hit) begin
      r_valid[w_u_index] <= 1'b1;
    end
  end

  // Payload of invalid entries is don't-care, so the arrays carry no reset.
  always_ff @(posedge clk) begin
    if (w_u_write) begin
      if (w_u_hit) begin
        r_counter[w_u_index] <= w_u_counter_next;
        if (update_taken) begin
          r_target[w_u_index] <= update_target;
        end
      end else begin
        r_tag[w_u_index]     <= w_u_tag;
        r_target[w_u_index]  <= update_target;
        r_counter[w_u_index] <= 2'b10;
      end
    end
  end

  assign predict_valid  = r_predict_valid;
  assign predict_taken  = r_predict_taken;
  assign predict_target = r_predict_target;

endmodule

// File: tb/tb_cpu_branch_predictor.sv
// tb/tb_cpu_branch_predictor.sv - scoreboard bench for cpu_branch_predictor
module tb_cpu_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        query_valid;
  logic [31:0] query_pc;
  logic        predict_valid;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        flush;

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  cpu_branch_predictor #(.ENTRY_COUNT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .query_valid   (query_valid),
    .query_pc      (query_pc),
    .predict_valid (predict_valid),
    .predict_taken (predict_taken),
    .predict_target(predict_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every presented prediction against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (predict_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_prediction: got taken=%0b target=%h, required no prediction",
                   predict_taken, predict_target);
        end else begin
          e = exp_q.pop_front();
          if (predict_taken !== e.taken || predict_target !== e.target) begin
            failures++;
            $display("FAIL prediction: got taken=%0b target=%h, required taken=%0b target=%h",
                     predict_taken, predict_target, e.taken, e.target);
          end
        end
      end else begin
        checks++;
        if (predict_taken !== 1'b0 || predict_target !== 32'd0) begin
          failures++;
          $display("FAIL idle_outputs: got taken=%0b target=%h, required 0 and 00000000",
                   predict_taken, predict_target);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic idle_inputs();
    query_valid   = 1'b0;
    query_pc      = 32'd0;
    update_valid  = 1'b0;
    update_pc     = 32'd0;
    update_taken  = 1'b0;
    update_target = 32'd0;
    flush         = 1'b0;
  endtask

  // One cycle of stimulus; a query pushes its hand-computed expectation.
  task automatic cyc(input logic qv, input logic [31:0] qpc,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic fl,
                     input logic et, input logic [31:0] etgt);
    exp_t e;
    query_valid   = qv;
    query_pc      = qpc;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    flush         = fl;
    if (qv) begin
      e.taken  = et;
      e.target = etgt;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic q(input logic [31:0] pc, input logic et, input logic [31:0] etgt);
    cyc(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, et, etgt);
  endtask

  task automatic u(input logic [31:0] pc, input logic ut, input logic [31:0] tgt);
    cyc(1'b0, 32'd0, 1'b1, pc, ut, tgt, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst_n = 1'b0;
    // Queries issued while reset is held must never yield a prediction.
    query_valid = 1'b1;
    query_pc    = 32'h100;
    @(posedge clk);
    #1;
    check("reset_valid",  {31'd0, predict_valid}, 32'd0);
    check("reset_taken",  {31'd0, predict_taken}, 32'd0);
    check("reset_target", predict_target, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;

    q(32'h100, 1'b0, 32'h104);
    u(32'h100, 1'b1, 32'h200);
    q(32'h100, 1'b1, 32'h200);
    u(32'h100, 1'b0, 32'h0);
    u(32'h100, 1'b0, 32'h0);
    q(32'h100, 1'b0, 32'h104);
    u(32'h100, 1'b0, 32'h0);
    q(32'h100, 1'b0, 32'h104);
    for (int i = 0; i < 4; i++) u(32'h100, 1'b1, 32'h300);
    q(32'h100, 1'b1, 32'h300);
    u(32'h100, 1'b0, 32'h444);
    q(32'h100, 1'b1, 32'h300);
    q(32'h140, 1'b0, 32'h144);
    u(32'h100, 1'b0, 32'h0);
    q(32'h100, 1'b0, 32'h104);

    cyc(1'b1, 32'h180, 1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 1'b0, 32'h184);
    q(32'h180, 1'b1, 32'h500);
    q(32'h100, 1'b0, 32'h104);
    cyc(1'b1, 32'h180, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b1, 32'h500);
    q(32'h180, 1'b0, 32'h184);
    u(32'h180, 1'b1, 32'h600);
    u(32'h1C0, 1'b0, 32'h0);
    q(32'h180, 1'b1, 32'h600);

    u(32'h24, 1'b1, 32'h1000);
    q(32'h24, 1'b1, 32'h1000);

    u(32'h100, 1'b1, 32'h200);
    cyc(1'b1, 32'h100, 1'b1, 32'h44, 1'b1, 32'h700, 1'b1, 1'b1, 32'h200);
    q(32'h100, 1'b0, 32'h104);
    q(32'h24,  1'b0, 32'h28);
    q(32'h44,  1'b0, 32'h48);
    q(32'hFFFFFFFC, 1'b0, 32'h0);

    u(32'h100, 1'b1, 32'h200);
    q(32'h100, 1'b1, 32'h200);
    // Query left in flight with no expectation: reset must drop it between edges.
    query_valid = 1'b1;
    query_pc    = 32'h100;
    @(posedge clk);
    #1;
    query_valid = 1'b0;
    check("pre_reset_valid", {31'd0, predict_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid",  {31'd0, predict_valid}, 32'd0);
    check("async_reset_taken",  {31'd0, predict_taken}, 32'd0);
    check("async_reset_target", predict_target, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q(32'h100, 1'b0, 32'h104);
    q(32'h24,  1'b0, 32'h28);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_branch_predictor.md
CPU_BRANCH_PREDICTOR -- requirements
Module: cpu_branch_predictor

Interface
REQ-001 Parameter ENTRY_COUNT, default 16, number of direct-mapped predictor entries; SHALL be a power of two, 4 to 256.
REQ-002 Derived INDEX_BITS = log2(ENTRY_COUNT); TAG_BITS = 30 - INDEX_BITS.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 query_valid  input  1  fetch requests a prediction this cycle.
REQ-006 query_pc  input  32  fetch PC; bits [1:0] ignored.
REQ-007 predict_valid  output  1  prediction outputs valid this cycle.
REQ-008 predict_taken  output  1  predicted branch outcome.
REQ-009 predict_target  output  32  predicted next PC.
REQ-010 update_valid  input  1  execute stage resolved a conditional branch this cycle.
REQ-011 update_pc  input  32  PC of resolved branch.
REQ-012 update_taken  input  1  resolved outcome, driven from the branch condition evaluator.
REQ-013 update_target  input  32  resolved taken target.
REQ-014 flush  input  1  synchronous invalidate of all entries.

Function
REQ-015 Entry fields: valid (1), tag (TAG_BITS = pc[31:INDEX_BITS+2]), target (32), counter (2); index = pc[INDEX_BITS+1:2].
REQ-016 Counter states: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-017 Lookup latency exactly 1 cycle: query in cycle N SHALL produce predict_* in cycle N+1; predict_valid(N+1) = query_valid(N).
REQ-018 Hit = entry valid and stored tag equals query tag.
REQ-019 Hit with counter[1]=1: predict_taken=1, predict_target=stored target.
REQ-020 Miss, or hit with counter[1]=0: predict_taken=0, predict_target=query_pc+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
REQ-021 predict_taken and predict_target SHALL be registered; held at 0 when predict_valid=0.
REQ-022 Update hit: counter increments saturating at 11 if update_taken, else decrements saturating at 00; target overwritten with update_target only if update_taken.
REQ-023 Update miss with update_taken=1: allocate/replace entry: valid=1, tag from update_pc, target=update_target, counter=10.
REQ-024 Update miss with update_taken=0: no table change.
REQ-025 Query and update in same cycle, same index: lookup SHALL use table contents before the update (read-before-write); update takes effect from next cycle.
REQ-026 flush=1: all valid bits cleared at the edge; any update in the same cycle is discarded; a query in the same cycle still completes against pre-flush contents.
REQ-027 Counters and targets of invalid entries are don't-care; only valid bits are required to be reset/flushed.
REQ-028 No backpressure: one query and one update accepted every cycle.

Reset
REQ-029 rst_n low SHALL immediately clear all valid bits, predict_valid, predict_taken, predict_target to 0, without waiting for clk.
REQ-030 A query issued in the cycle reset asserts SHALL produce no prediction; first valid prediction is one cycle after the first post-reset query.
REQ-031 After reset every lookup misses until allocated by REQ-023.

Verification
REQ-032 Post-reset query pc=0x00000100 -> next cycle predict_valid=1, taken=0, target=0x00000104.
REQ-033 Update pc=0x100 taken target=0x200, then query 0x100 -> taken=1, target=0x200; two not-taken updates -> counter 00, query -> taken=0, target=0x104.
REQ-034 Four taken updates at 0x100 -> counter saturates 11; one not-taken -> still taken=1; alias pc=0x140 (ENTRY_COUNT=16) query -> miss, taken=0, target=0x144.
REQ-035 Same-cycle query and taken allocate at 0x180 -> prediction that cycle taken=0; repeat query next cycle -> taken=1.
REQ-036 Allocate 0x100, assert flush with simultaneous update -> next query misses; query pc=0xFFFFFFFC -> target=0x00000000.
REQ-037 Assert rst_n low mid-stream between edges -> predict_valid drops to 0 asynchronously; all entries miss after release.
